// File: rtl/pc_seq_unit.sv
// pc_seq_unit: program counter sequencer with a return-address stack.
// Supports NOP, INC, ASSIGN, RESET, CALL, RET and signed relative branch.
// Optional macro PCU_IRQ_EN adds a single-level interrupt (irq_req/irq_ack,
// RETI opcode). The default build without the macro has no interrupt logic.
module pc_seq_unit #(
   parameter int PC_WIDTH = 16,
   parameter int STACK_DEPTH = 8,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
`ifdef PCU_IRQ_EN
   ,
   parameter logic [PC_WIDTH-1:0] IRQ_VECTOR = PC_WIDTH'(16'h0010)
`endif
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [PC_WIDTH-1:0]              pc_in,
   input  logic [2:0]                       pc_op,
   input  logic                             stall,
`ifdef PCU_IRQ_EN
   input  logic                             irq_req,
   output logic                             irq_ack,
`endif
   output logic [PC_WIDTH-1:0]              pc_out,
   output logic [$clog2(STACK_DEPTH):0]     sp_out,
   output logic                             stack_overflow,
   output logic                             stack_underflow
);

   localparam int IDXW = $clog2(STACK_DEPTH);
   localparam int SPW  = IDXW + 1;

   localparam logic [2:0] OP_NOP    = 3'd0;
   localparam logic [2:0] OP_INC    = 3'd1;
   localparam logic [2:0] OP_ASSIGN = 3'd2;
   localparam logic [2:0] OP_RESET  = 3'd3;
   localparam logic [2:0] OP_CALL   = 3'd4;
   localparam logic [2:0] OP_RET    = 3'd5;
   localparam logic [2:0] OP_BRREL  = 3'd6;
`ifdef PCU_IRQ_EN
   localparam logic [2:0] OP_RETI   = 3'd7;
`endif

   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [SPW-1:0]      sp_q, sp_d;
   logic                overflow_q, overflow_d;
   logic                underflow_q, underflow_d;
   logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];

   logic                pushEn;
   logic [PC_WIDTH-1:0] pushData;
   logic [IDXW-1:0]     pushIdx;
   logic [IDXW-1:0]     popIdx;
   logic                stackFull;
   logic                stackEmpty;
   logic [PC_WIDTH-1:0] pcPlusOne;

`ifdef PCU_IRQ_EN
   logic                inService_q, inService_d;
   logic                irqAck_q, irqAck_d;
`endif

   assign pushIdx    = sp_q[IDXW-1:0];
   assign popIdx     = IDXW'(sp_q - SPW'(1));
   assign stackFull  = (sp_q == SPW'(STACK_DEPTH));
   assign stackEmpty = (sp_q == '0);
   assign pcPlusOne  = pc_q + PC_WIDTH'(1);

   // Next-state decode: pick the new PC, stack pointer, flags and any push.
   always_comb begin
      pc_d        = pc_q;
      sp_d        = sp_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      pushEn      = 1'b0;
      pushData    = pcPlusOne;
`ifdef PCU_IRQ_EN
      inService_d = inService_q;
      irqAck_d    = 1'b0;
`endif
      if (!stall) begin
`ifdef PCU_IRQ_EN
         if (irq_req && (pc_op != OP_RESET) && !inService_q) begin
            pc_d        = IRQ_VECTOR;
            inService_d = 1'b1;
            irqAck_d    = 1'b1;
            pushData    = pc_q;
            if (stackFull) begin
               overflow_d = 1'b1;
            end else begin
               pushEn = 1'b1;
               sp_d   = sp_q + SPW'(1);
            end
         end else begin
`endif
            case (pc_op)
               OP_NOP: begin
                  pc_d = pc_q;
               end
               OP_INC: begin
                  pc_d = pcPlusOne;
               end
               OP_ASSIGN: begin
                  pc_d = pc_in;
               end
               OP_RESET: begin
                  pc_d        = RESET_VECTOR;
                  sp_d        = '0;
                  overflow_d  = 1'b0;
                  underflow_d = 1'b0;
`ifdef PCU_IRQ_EN
                  inService_d = 1'b0;
`endif
               end
               OP_CALL: begin
                  pc_d = pc_in;
                  if (stackFull) begin
                     overflow_d = 1'b1;
                  end else begin
                     pushEn = 1'b1;
                     sp_d   = sp_q + SPW'(1);
                  end
               end
               OP_RET: begin
                  if (stackEmpty) begin
                     pc_d        = pcPlusOne;
                     underflow_d = 1'b1;
                  end else begin
                     pc_d = stack_q[popIdx];
                     sp_d = sp_q - SPW'(1);
                  end
               end
               OP_BRREL: begin
                  pc_d = pc_q + pc_in;
               end
`ifdef PCU_IRQ_EN
               OP_RETI: begin
                  inService_d = 1'b0;
                  if (stackEmpty) begin
                     pc_d        = pcPlusOne;
                     underflow_d = 1'b1;
                  end else begin
                     pc_d = stack_q[popIdx];
                     sp_d = sp_q - SPW'(1);
                  end
               end
`endif
               default: begin
                  pc_d = pc_q;
               end
            endcase
`ifdef PCU_IRQ_EN
         end
`endif
      end
   end

   // Control registers; the reset port wins over stall and every opcode.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q        <= RESET_VECTOR;
         sp_q        <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
`ifdef PCU_IRQ_EN
         inService_q <= 1'b0;
         irqAck_q    <= 1'b0;
`endif
      end else begin
         pc_q        <= pc_d;
         sp_q        <= sp_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
`ifdef PCU_IRQ_EN
         inService_q <= inService_d;
         irqAck_q    <= irqAck_d;
`endif
      end
   end

   // Return-address storage; contents are don't-care, only sp_q qualifies them.
   always_ff @(posedge clk) begin
      if (pushEn && !reset) begin
         stack_q[pushIdx] <= pushData;
      end
   end

   assign pc_out          = pc_q;
   assign sp_out          = sp_q;
   assign stack_overflow  = overflow_q;
   assign stack_underflow = underflow_q;
`ifdef PCU_IRQ_EN
   assign irq_ack         = irqAck_q;
`endif

endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: directed self-checking bench for pc_seq_unit.
// Interrupt scenarios are compiled only when PCU_IRQ_EN is defined.
module tb_pc_seq_unit;

   localparam logic [2:0] OP_NOP    = 3'd0;
   localparam logic [2:0] OP_INC    = 3'd1;
   localparam logic [2:0] OP_ASSIGN = 3'd2;
   localparam logic [2:0] OP_RESET  = 3'd3;
   localparam logic [2:0] OP_CALL   = 3'd4;
   localparam logic [2:0] OP_RET    = 3'd5;
   localparam logic [2:0] OP_BRREL  = 3'd6;
`ifdef PCU_IRQ_EN
   localparam logic [2:0] OP_RETI   = 3'd7;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] pc_in = '0;
   logic [2:0]  pc_op = OP_NOP;
   logic        stall = 1'b0;
   logic [15:0] pc_out;
   logic [3:0]  sp_out;
   logic        stack_overflow;
   logic        stack_underflow;
`ifdef PCU_IRQ_EN
   logic        irq_req = 1'b0;
   logic        irq_ack;
`endif

   int testsRun = 0;
   int testsFailed = 0;

   pc_seq_unit dut (
      .clk             (clk),
      .reset           (reset),
      .pc_in           (pc_in),
      .pc_op           (pc_op),
      .stall           (stall),
`ifdef PCU_IRQ_EN
      .irq_req         (irq_req),
      .irq_ack         (irq_ack),
`endif
      .pc_out          (pc_out),
      .sp_out          (sp_out),
      .stack_overflow  (stack_overflow),
      .stack_underflow (stack_underflow)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Advance one rising edge and settle before sampling or driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Apply one opcode for one cycle, then return to NOP.
   task automatic applyStimulus(input logic [2:0] op, input logic [15:0] target);
      pc_op = op;
      pc_in = target;
      tick();
      pc_op = OP_NOP;
   endtask

   // Compare the full visible state against hand-computed values.
   task automatic checkOutput(input string name, input logic [15:0] expPc,
                              input logic [3:0] expSp, input logic expOvf,
                              input logic expUnf);
      testsRun++;
      if (pc_out !== expPc || sp_out !== expSp ||
          stack_overflow !== expOvf || stack_underflow !== expUnf) begin
         testsFailed++;
         $display("[TB] FAIL %s: got pc=%h sp=%0d ovf=%b unf=%b, expected pc=%h sp=%0d ovf=%b unf=%b",
                  name, pc_out, sp_out, stack_overflow, stack_underflow,
                  expPc, expSp, expOvf, expUnf);
      end
   endtask

   task automatic doReset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Reset wins even with stall high and a CALL on pc_op.
   task automatic test_reset();
      reset = 1'b1;
      stall = 1'b1;
      pc_op = OP_CALL;
      pc_in = 16'h1234;
      tick();
      checkOutput("reset_state", 16'h0000, 4'd0, 1'b0, 1'b0);
      reset = 1'b0;
      stall = 1'b0;
      pc_op = OP_NOP;
   endtask

   // Three INCs walk the PC 0,1,2,3.
   task automatic test_inc();
      doReset();
      checkOutput("inc_start", 16'h0000, 4'd0, 1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(OP_INC, 16'h0000);
         checkOutput($sformatf("inc_%0d", i), 16'(i), 4'd0, 1'b0, 1'b0);
      end
   endtask

   // Single CALL then RET returns to the address after the call site.
   task automatic test_call_ret();
      doReset();
      applyStimulus(OP_ASSIGN, 16'h0100);
      checkOutput("assign_0100", 16'h0100, 4'd0, 1'b0, 1'b0);
      applyStimulus(OP_CALL, 16'h0200);
      checkOutput("call_0200", 16'h0200, 4'd1, 1'b0, 1'b0);
      applyStimulus(OP_RET, 16'h0000);
      checkOutput("ret_0101", 16'h0101, 4'd0, 1'b0, 1'b0);
   endtask

   // Nine CALLs overflow, eight RETs unwind LIFO, ninth RET underflows.
   task automatic test_overflow();
      logic [15:0] expRet;
      doReset();
      for (int i = 0; i < 9; i++) begin
         applyStimulus(OP_CALL, 16'h1000 + 16'(i));
         checkOutput($sformatf("call_%0d", i), 16'h1000 + 16'(i),
                     (i < 8) ? 4'(i + 1) : 4'd8, (i == 8), 1'b0);
      end
      for (int k = 7; k >= 0; k--) begin
         expRet = (k == 0) ? 16'h0001 : 16'h1000 + 16'(k);
         applyStimulus(OP_RET, 16'h0000);
         checkOutput($sformatf("ret_%0d", k), expRet, 4'(k), 1'b1, 1'b0);
      end
      applyStimulus(OP_RET, 16'h0000);
      checkOutput("ret_underflow", 16'h0002, 4'd0, 1'b1, 1'b1);
   endtask

   // Modular INC wrap and signed relative branches.
   task automatic test_wrap_brrel();
      doReset();
      applyStimulus(OP_ASSIGN, 16'hFFFF);
      applyStimulus(OP_INC, 16'h0000);
      checkOutput("inc_wrap", 16'h0000, 4'd0, 1'b0, 1'b0);
      applyStimulus(OP_ASSIGN, 16'h0005);
      applyStimulus(OP_BRREL, 16'hFFFE);
      checkOutput("brrel_minus2", 16'h0003, 4'd0, 1'b0, 1'b0);
      applyStimulus(OP_BRREL, 16'h0000);
      checkOutput("brrel_zero", 16'h0003, 4'd0, 1'b0, 1'b0);
      applyStimulus(OP_BRREL, 16'h0010);
      checkOutput("brrel_plus16", 16'h0013, 4'd0, 1'b0, 1'b0);
   endtask

   // Stall freezes everything for every opcode.
   task automatic test_stall();
      doReset();
      applyStimulus(OP_ASSIGN, 16'h0300);
      applyStimulus(OP_CALL, 16'h0400);
      checkOutput("stall_setup", 16'h0400, 4'd1, 1'b0, 1'b0);
      stall = 1'b1;
      for (int op = 0; op < 8; op++) begin
         applyStimulus(3'(op), 16'h0ABC);
         checkOutput($sformatf("stall_op%0d", op), 16'h0400, 4'd1, 1'b0, 1'b0);
      end
      stall = 1'b0;
      applyStimulus(OP_RET, 16'h0000);
      checkOutput("stall_release_ret", 16'h0301, 4'd0, 1'b0, 1'b0);
   endtask

   // Sticky underflow survives other ops; OP_RESET clears it and the stack.
   task automatic test_op_reset();
      doReset();
      applyStimulus(OP_RET, 16'h0000);
      checkOutput("unf_set", 16'h0001, 4'd0, 1'b0, 1'b1);
      applyStimulus(OP_CALL, 16'h0050);
      applyStimulus(OP_INC, 16'h0000);
      checkOutput("unf_sticky", 16'h0051, 4'd1, 1'b0, 1'b1);
      applyStimulus(OP_RESET, 16'h0000);
      checkOutput("op_reset", 16'h0000, 4'd0, 1'b0, 1'b0);
      applyStimulus(OP_NOP, 16'h0000);
      checkOutput("nop_hold", 16'h0000, 4'd0, 1'b0, 1'b0);
   endtask

   // Reset between CALL and RET drops the stacked address.
   task automatic test_reset_mid();
      doReset();
      applyStimulus(OP_ASSIGN, 16'h0700);
      applyStimulus(OP_CALL, 16'h0800);
      checkOutput("mid_call", 16'h0800, 4'd1, 1'b0, 1'b0);
      doReset();
      applyStimulus(OP_RET, 16'h0000);
      checkOutput("mid_ret_underflow", 16'h0001, 4'd0, 1'b0, 1'b1);
   endtask

`ifdef PCU_IRQ_EN
   // Interrupt entry, no nesting, RETI return, then re-acceptance.
   task automatic test_irq();
      doReset();
      applyStimulus(OP_ASSIGN, 16'h0040);
      irq_req = 1'b1;
      applyStimulus(OP_INC, 16'h0000);
      checkOutput("irq_entry", 16'h0010, 4'd1, 1'b0, 1'b0);
      testsRun++;
      if (irq_ack !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL irq_ack_high: got %b expected 1", irq_ack);
      end
      applyStimulus(OP_INC, 16'h0000);
      checkOutput("irq_nested_ignored", 16'h0011, 4'd1, 1'b0, 1'b0);
      testsRun++;
      if (irq_ack !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL irq_ack_pulse: got %b expected 0", irq_ack);
      end
      irq_req = 1'b0;
      applyStimulus(OP_RETI, 16'h0000);
      checkOutput("reti", 16'h0040, 4'd0, 1'b0, 1'b0);
      irq_req = 1'b1;
      applyStimulus(OP_NOP, 16'h0000);
      checkOutput("irq_again", 16'h0010, 4'd1, 1'b0, 1'b0);
      testsRun++;
      if (irq_ack !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL irq_ack_again: got %b expected 1", irq_ack);
      end
      irq_req = 1'b0;
   endtask
`endif

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_inc();
      test_call_ret();
      test_overflow();
      test_wrap_brrel();
      test_stall();
      test_op_reset();
      test_reset_mid();
`ifdef PCU_IRQ_EN
      test_irq();
`endif
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
